// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) requesters, with a bus timeout.
// Define MEM_ARB_ROUND_ROBIN_EN to break I/D ties by last owner instead of fixed D priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    iReq,
    input  logic [ADDR_WIDTH-1:0]   iAddr,
    output logic                    iGnt,
    output logic                    iValid,
    output logic [DATA_WIDTH-1:0]   iRData,
    output logic                    iErr,

    input  logic                    dReq,
    input  logic                    dWe,
    input  logic [ADDR_WIDTH-1:0]   dAddr,
    input  logic [DATA_WIDTH-1:0]   dWData,
    input  logic [DATA_WIDTH/8-1:0] dStrb,
    output logic                    dGnt,
    output logic                    dValid,
    output logic [DATA_WIDTH-1:0]   dRData,
    output logic                    dErr,

    output logic                    memReq,
    output logic                    memWe,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic [DATA_WIDTH-1:0]   memWData,
    output logic [DATA_WIDTH/8-1:0] memStrb,
    input  logic                    memAck,
    input  logic [DATA_WIDTH-1:0]   memRData
);

    localparam int unsigned StrbWidth    = DATA_WIDTH / 8;
    localparam logic [7:0]  TimeoutLimit = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic                   owner_is_d_q, owner_is_d_d;
    logic                   last_is_d_q, last_is_d_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [StrbWidth-1:0]   mem_strb_q, mem_strb_d;

    logic                   i_gnt_q, i_gnt_d;
    logic                   d_gnt_q, d_gnt_d;
    logic                   i_valid_q, i_valid_d;
    logic                   d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic                   i_err_q, i_err_d;
    logic                   d_err_q, d_err_d;

    logic                   req_any;
    logic                   sel_d;
    logic                   timeout_hit;
    logic                   resp_err;
    logic [DATA_WIDTH-1:0]  resp_rdata;

    assign req_any = iReq | dReq;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins.
    assign sel_d = dReq & (~iReq | ~last_is_d_q);
`else
    logic unused_last_owner;
    assign sel_d             = dReq;
    assign unused_last_owner = last_is_d_q;
`endif

    // cnt_q counts completed BUSY cycles, so the limit is reached in the last allowed cycle.
    assign timeout_hit = (cnt_q + 8'd1) == TimeoutLimit;
    assign resp_err    = ~memAck;
    assign resp_rdata  = (memAck && !mem_we_q) ? memRData : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (memAck || timeout_hit) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and datapath next values; every port output comes straight from a flop.
    always_comb begin
        owner_is_d_d = owner_is_d_q;
        last_is_d_d  = last_is_d_q;
        cnt_d        = cnt_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_strb_d   = mem_strb_q;
        i_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_any) begin
                    owner_is_d_d = sel_d;
                    mem_req_d    = 1'b1;
                    d_gnt_d      = sel_d;
                    i_gnt_d      = ~sel_d;
                    if (sel_d) begin
                        mem_we_d    = dWe;
                        mem_addr_d  = dAddr;
                        mem_wdata_d = dWData;
                        mem_strb_d  = dWe ? dStrb : '1;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = iAddr;
                        mem_wdata_d = '0;
                        mem_strb_d  = '1;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 8'd1;
                if (memAck || timeout_hit) begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_strb_d  = '0;
                    if (owner_is_d_q) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = resp_rdata;
                        d_err_d   = resp_err;
                    end else begin
                        i_valid_d = 1'b1;
                        i_rdata_d = resp_rdata;
                        i_err_d   = resp_err;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    d_gnt_d   = owner_is_d_q;
                    i_gnt_d   = ~owner_is_d_q;
                end
            end
            StResp: begin
                cnt_d       = '0;
                last_is_d_d = owner_is_d_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_is_d_q <= 1'b0;
            last_is_d_q  <= 1'b1;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            owner_is_d_q <= owner_is_d_d;
            last_is_d_q  <= last_is_d_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strb_q   <= mem_strb_d;
            i_gnt_q      <= i_gnt_d;
            d_gnt_q      <= d_gnt_d;
            i_valid_q    <= i_valid_d;
            d_valid_q    <= d_valid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWData = mem_wdata_q;
    assign memStrb  = mem_strb_q;
    assign iGnt     = i_gnt_q;
    assign dGnt     = d_gnt_q;
    assign iValid   = i_valid_q;
    assign dValid   = d_valid_q;
    assign iRData   = i_rdata_q;
    assign dRData   = d_rdata_q;
    assign iErr     = i_err_q;
    assign dErr     = d_err_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(iGnt && dGnt));
    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(iValid && dValid));
    a_valid_no_req: assert property (@(posedge clk) disable iff (!rst_n)
                                     (iValid || dValid) |-> !memReq);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester (I) and the load/store requester (D) of the multicycle controller. Accepts one request at a time, drives the memory port, waits for the memory acknowledge, and returns read data or an error to the owning requester. A bus timeout guards against a memory that never acknowledges. The block sits between the main controller/datapath and the unified instruction/data memory.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 15, maximum cycles to wait for memAck; legal range 1..255
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- iReq  in  1  fetch request; held with iAddr until iValid
- iAddr  in  ADDR_WIDTH  fetch address
- iGnt  out  1  fetch owns the memory port (BUSY state)
- iValid  out  1  one-cycle response pulse to fetch
- iRData  out  DATA_WIDTH  fetched word, valid with iValid
- iErr  out  1  timeout error, valid with iValid
- dReq  in  1  load/store request; held with dWe/dAddr/dWData/dStrb until dValid
- dWe  in  1  1 = store, 0 = load
- dAddr  in  ADDR_WIDTH  data address
- dWData  in  DATA_WIDTH  store data
- dStrb  in  DATA_WIDTH/8  store byte enables
- dGnt  out  1  data port owns the memory port
- dValid  out  1  one-cycle response pulse to data port
- dRData  out  DATA_WIDTH  load data, valid with dValid
- dErr  out  1  timeout error, valid with dValid
- memReq  out  1  memory request, held until memAck or timeout
- memWe  out  1  memory write enable
- memAddr  out  ADDR_WIDTH  memory address
- memWData  out  DATA_WIDTH  memory write data
- memStrb  out  DATA_WIDTH/8  memory byte enables (all ones for fetch/load)
- memAck  in  1  memory completion, single-cycle
- memRData  in  DATA_WIDTH  memory read data, valid with memAck

## Operation
- Reset: state IDLE; every output 0; timeout counter 0; last-owner flag = D.
- States: IDLE, BUSY, RESP.
- IDLE: if any request, select an owner; register its address/we/wdata/strb into mem* outputs (fetch: memWe=0, memStrb all ones); go to BUSY. No request: stay.
- Selection without the macro: D has fixed priority over I.
- BUSY: memReq=1, owner's Gnt=1, counter increments each cycle. memAck → capture memRData into owner's RData (writes: RData=0), Err=0, go to RESP. Counter reaches TIMEOUT_CYCLES with no memAck → RData=0, Err=1, go to RESP.
- memAck and timeout in the same cycle: ack wins, Err=0.
- RESP: memReq=0, Gnts=0, owner's Valid=1 for exactly one cycle; last-owner flag updated; go to IDLE.
- RData/Err hold their values until the next response to that port.
- memAck outside BUSY is ignored.
- Requester inputs are sampled only in IDLE; changes during BUSY/RESP have no effect.
- Reset mid-transaction aborts it: memReq drops immediately (asynchronously), no Valid is issued.

## Timing
- Request seen in IDLE at cycle 0 → memReq high from cycle 1.
- memAck in cycle k (k ≥ 1) → Valid in cycle k+1 → IDLE in cycle k+2.
- Minimum round trip: 3 cycles (memAck in cycle 1).
- Requester deasserts Req in the Valid cycle or earlier. A Req still high in cycle k+2 is treated as a new request.
- Timeout: memReq is high for exactly TIMEOUT_CYCLES cycles, then Err/Valid follow in the next cycle.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when iReq and dReq are both high in IDLE, the port not served last wins. Because the last-owner flag resets to D, the first tie goes to I. A single requester is always granted.
- Undefined: fixed priority, D over I; the last-owner flag exists but has no effect.

## Test plan
- Single fetch: iReq, iAddr=0x100, memAck 2 cycles after memReq with memRData=0xDEADBEEF → iValid one cycle later with iRData=0xDEADBEEF, iErr=0, memWe=0, memStrb=0xF.
- Store: dReq, dWe=1, dAddr=0x200, dWData=0x12345678, dStrb=0x3 → memWe=1, memAddr=0x200, memStrb=0x3 while memReq is high; dValid with dRData=0.
- Simultaneous iReq/dReq, four back-to-back rounds: without the macro, D is granted every round; with the macro, the grant order is I, D, I, D.
- Timeout: TIMEOUT_CYCLES=4, no memAck → memReq high exactly 4 cycles, then dValid=1, dErr=1, dRData=0. A later memAck in IDLE is ignored.
- Ack/timeout collision: memAck in the 4th BUSY cycle with TIMEOUT_CYCLES=4 → Err=0, data captured.
- Reset asserted during BUSY → memReq, Gnt and Valid all 0 immediately. After release, state is IDLE and a new iReq is served normally.
